// File: rtl/spi_slave_if.sv
// SPI target port: oversampled sclk/mosi/cs_n, host-preloaded tx byte, rx buffer and irq.
// Define SPI_SLV_RXFIFO_EN to replace the single rx buffer with a FIFO_DEPTH-entry FIFO.
module spi_slave_if #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] din,
  input  logic       cmd,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] dout,
  output logic [3:0] status,
  output logic       irq
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync;
  logic                   sclk_q, csn_q;
  logic                   sclk_s, mosi_s, csn_s;
  logic [1:0]             mode, frame_mode;
  logic                   irq_en, udr, ovr, rx_valid;
  logic [7:0]             tx_buf, tx_shr, rx_shr, rx_byte, load_byte;
  logic                   tx_full, hold;
  logic [2:0]             bit_cnt;
  logic                   cs_fall, cs_rise, lead, trail, active;
  logic                   sample_edge, shift_edge, byte_end, reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_sync  <= '1;
      sclk_q    <= 1'b0;
      csn_q     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], cs_n};
      sclk_q    <= sclk_s;
      csn_q     <= csn_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign csn_s  = csn_sync[SYNC_STAGES-1];

  assign cs_fall     = csn_q & ~csn_s;
  assign cs_rise     = ~csn_q & csn_s;
  assign lead        = frame_mode[1] ? (sclk_q & ~sclk_s) : (~sclk_q & sclk_s);
  assign trail       = (sclk_q ^ sclk_s) & ~lead;
  assign active      = (state == StActive) & ~cs_rise;
  assign sample_edge = active & (frame_mode[0] ? trail : lead);
  assign shift_edge  = active & (frame_mode[0] ? lead : trail);
  assign byte_end    = sample_edge & (bit_cnt == 3'd7);
  assign rx_byte     = {rx_shr[6:0], mosi_s};
  assign reload      = ((state == StIdle) & cs_fall) | byte_end;
  assign load_byte   = tx_full ? tx_buf : FILL_BYTE;

  // hold parks a freshly loaded byte so its MSB survives the next shift edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      frame_mode <= 2'b00;
      mode       <= 2'b00;
      irq_en     <= 1'b0;
      udr        <= 1'b0;
      tx_buf     <= 8'h00;
      tx_full    <= 1'b0;
      tx_shr     <= 8'h00;
      rx_shr     <= 8'h00;
      bit_cnt    <= 3'd0;
      hold       <= 1'b0;
    end else begin
      if (cmd) begin
        mode   <= din[1:0];
        irq_en <= din[2];
        if (din[7]) udr <= 1'b0;
      end
      if (reload && !tx_full) udr <= 1'b1;
      if (wr) begin
        tx_buf  <= din;
        tx_full <= 1'b1;
      end else if (reload) begin
        tx_full <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (cs_fall) begin
            state      <= StActive;
            frame_mode <= mode;
            bit_cnt    <= 3'd0;
            hold       <= mode[0];
            tx_shr     <= load_byte;
          end
        end
        StActive: begin
          if (cs_rise) begin
            state   <= StIdle;
            bit_cnt <= 3'd0;
            tx_shr  <= 8'h00;
          end else begin
            if (sample_edge) begin
              rx_shr  <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_end) begin
              tx_shr <= load_byte;
              hold   <= 1'b1;
            end else if (shift_edge) begin
              if (hold) hold <= 1'b0;
              else      tx_shr <= {tx_shr[6:0], 1'b0};
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef SPI_SLV_RXFIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = rd & ~empty;
  assign push  = byte_end & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 8'h00;
      wptr <= '0;
      rptr <= '0;
      ovr  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= rx_byte;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
      if (cmd && din[7]) ovr <= 1'b0;
      if (byte_end && full && !pop) ovr <= 1'b1;
    end
  end

  assign rx_valid = ~empty;
  assign dout     = mem[rptr[AW-1:0]];
`else
  logic [7:0]  rx_buf;
  logic [31:0] unused_depth;

  assign unused_depth = FIFO_DEPTH;

  // A full buffer keeps its old byte unless the host pops in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_buf   <= 8'h00;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (cmd && din[7]) ovr <= 1'b0;
      if (byte_end) begin
        if (rx_valid && !rd) begin
          ovr <= 1'b1;
        end else begin
          rx_buf   <= rx_byte;
          rx_valid <= 1'b1;
        end
      end else if (rd) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign dout = rx_buf;
`endif

  assign miso    = tx_shr[7];
  assign miso_oe = (state == StActive);
  assign status  = {miso_oe, udr, ovr, rx_valid};
  assign irq     = irq_en & (rx_valid | ovr);

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed scenarios plus random frames checked against a
// queue-based model of the host-visible behaviour.
module tb_spi_slave_if;
  localparam int HALF = 8;
`ifdef SPI_SLV_RXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n, sclk, mosi, cs_n, miso, miso_oe, cmd, wr, rd, irq;
  logic [7:0] din, dout;
  logic [3:0] status;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];
  logic [7:0] exp_miso [4];
  logic [7:0] mq [$];
  logic [7:0] m_txb;
  bit         m_have_tx, m_udr, m_ovr, m_irq_en;

  int         rm, nb, nrd;
  bit         rclr, rie;

  always #5 clk = ~clk;

  spi_slave_if #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .din(din), .cmd(cmd), .wr(wr), .rd(rd),
    .dout(dout), .status(status), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  task automatic mdl_reset();
    mq.delete();
    m_have_tx = 0; m_udr = 0; m_ovr = 0; m_irq_en = 0;
  endtask

  task automatic mdl_reload(output logic [7:0] b);
    if (m_have_tx) b = m_txb;
    else begin
      b = 8'hFF;
      m_udr = 1;
    end
    m_have_tx = 0;
  endtask

  task automatic mdl_frame(input int nbytes);
    logic [7:0] b;
    mdl_reload(b);
    for (int i = 0; i < nbytes; i++) begin
      exp_miso[i] = b;
      if (mq.size() < DEPTH) mq.push_back(m_tx[i]);
      else m_ovr = 1;
      mdl_reload(b);
    end
  endtask

  task automatic mdl_rd();
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic check_state(input string tag);
    logic [3:0] es;
    es = {1'b0, m_udr, m_ovr, mq.size() != 0};
    chk({tag, " status"}, status, es);
    chk({tag, " irq"}, irq, m_irq_en & ((mq.size() != 0) | m_ovr));
    chk({tag, " miso_oe"}, miso_oe, 1'b0);
    if (mq.size() != 0) chk({tag, " dout"}, dout, mq[0]);
  endtask

  // Host side
  task automatic host_cmd(input logic [7:0] d);
    @(negedge clk); din = d; cmd = 1'b1;
    @(negedge clk); cmd = 1'b0;
    m_irq_en = d[2];
    if (d[7]) begin m_udr = 0; m_ovr = 0; end
  endtask

  task automatic host_wr(input logic [7:0] d);
    @(negedge clk); din = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    m_have_tx = 1; m_txb = d;
  endtask

  task automatic host_rd();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    mdl_rd();
  endtask

  // SPI master: nbits bits of m_tx MSB-first, miso collected into m_rx
  task automatic spi_xfer(input logic [1:0] m, input int nbits);
    int byt, bi;
    @(negedge clk); sclk = m[1];
    repeat (8) @(negedge clk);
    cs_n = 1'b0;
    if (!m[0]) mosi = m_tx[0][7];
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      byt = b / 8; bi = 7 - (b % 8);
      sclk = ~sclk;
      if (b == 0) begin
        chk("frame miso_oe", miso_oe, 1'b1);
        chk("frame busy", status[3], 1'b1);
      end
      if (!m[0]) m_rx[byt][bi] = miso;
      else mosi = m_tx[byt][bi];
      repeat (HALF) @(negedge clk);
      sclk = ~sclk;
      if (m[0]) m_rx[byt][bi] = miso;
      else if (b + 1 < nbits) mosi = m_tx[(b+1)/8][7-((b+1)%8)];
      repeat (HALF) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_frame(input logic [1:0] m, input int nbytes, input string tag);
    spi_xfer(m, nbytes * 8);
    mdl_frame(nbytes);
    for (int i = 0; i < nbytes; i++) chk({tag, " miso byte"}, m_rx[i], exp_miso[i]);
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    din = 8'h00; cmd = 1'b0; wr = 1'b0; rd = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk("reset miso", miso, 1'b0);
    chk("reset miso_oe", miso_oe, 1'b0);
    chk("reset dout", dout, 8'h00);
    chk("reset status", status, 4'h0);
    chk("reset irq", irq, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 0 basic byte with irq enabled
    host_cmd(8'h04);
    host_wr(8'hA5);
    m_tx[0] = 8'h3C;
    do_frame(2'd0, 1, "mode0");
    chk("mode0 dout 3C", dout, 8'h3C);
    host_rd();
    check_state("mode0 after rd");

    // Remaining modes
    for (int m = 1; m < 4; m++) begin
      host_cmd(8'h84 | 8'(m));
      host_wr(8'h96);
      m_tx[0] = 8'h69;
      do_frame(2'(m), 1, "modeN");
      host_rd();
    end

    // Underrun and overrun in a two-byte frame
    host_cmd(8'h80);
    m_tx[0] = 8'h01; m_tx[1] = 8'h02;
    do_frame(2'd0, 2, "udr_ovr");
    host_rd();
    check_state("drain1");
    host_rd();
    check_state("drain2");

    // Partial frame is discarded
    host_cmd(8'h80);
    spi_xfer(2'd0, 5);
    begin
      logic [7:0] b;
      mdl_reload(b);
    end
    check_state("partial");
    chk("partial miso", miso, 1'b0);
    m_tx[0] = 8'hC3;
    do_frame(2'd0, 1, "after partial");
    host_rd();

    // rd coincident with byte end
    host_cmd(8'h80);
    m_tx[0] = 8'h11;
    do_frame(2'd0, 1, "old byte");
    m_tx[0] = 8'hE7;
    fork
      spi_xfer(2'd0, 8);
      begin
        repeat (8) @(posedge sclk);
        @(negedge clk); @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0;
      end
    join
    mdl_rd();
    mdl_frame(1);
    chk("coincident miso byte", m_rx[0], exp_miso[0]);
    check_state("coincident rd");
    host_cmd(8'h80);
    check_state("cleared");
    host_rd();

    // Reset mid-byte
    host_cmd(8'h04);
    m_tx[0] = 8'hAA;
    fork
      spi_xfer(2'd0, 8);
      begin
        repeat (3) @(posedge sclk);
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst miso", miso, 1'b0);
        chk("rst miso_oe", miso_oe, 1'b0);
        chk("rst dout", dout, 8'h00);
        chk("rst status", status, 4'h0);
        chk("rst irq", irq, 1'b0);
      end
    join
    mdl_reset();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("post reset");
    host_cmd(8'h04);
    m_tx[0] = 8'h5A;
    do_frame(2'd0, 1, "post reset frame");
    chk("post reset dout 5A", dout, 8'h5A);
    host_rd();

    // Random frames
    for (int it = 0; it < 16; it++) begin
      rm   = int'($urandom_range(0, 3));
      rclr = 1'($urandom_range(0, 1));
      rie  = 1'($urandom_range(0, 1));
      host_cmd({rclr, 4'b0000, rie, 2'(rm)});
      if ($urandom_range(0, 1) == 1) host_wr(8'($urandom));
      nb = int'($urandom_range(1, 3));
      for (int i = 0; i < nb; i++) m_tx[i] = 8'($urandom);
      do_frame(2'(rm), nb, "random");
      nrd = int'($urandom_range(0, 2));
      for (int r = 0; r < nrd; r++) begin
        host_rd();
        check_state("random rd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
